// File: rtl/filter_pkg.sv
// ---------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the adaptive filter and its output conditioner.
//   - default word lengths of the filter output sample and conditioned word
//   - cond_state_t : conditioner FSM state (SETTLE while the filter recovers
//                    from a mode change, RUN otherwise)
//   - sat_signed() : clamp a signed value to a signed field of a given width
// ---------------------------------------------------------------------------
package filter_pkg;

   localparam int IN_WL_DEFAULT         = 24;  // filter accumulator word length
   localparam int IN_FL_DEFAULT         = 10;  // filter accumulator fractional bits
   localparam int OUT_WL_DEFAULT        = 14;  // conditioned output word length
   localparam int SETTLE_CYCLES_DEFAULT = 16;  // valid samples blanked after a mode change
   localparam int SAT_CNT_WL_DEFAULT    = 16;  // saturation event counter width

   typedef enum logic {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } cond_state_t;

   // Clamp value into the range of a signed integer of 'width' bits.
   // The caller detects clipping by comparing the result with the input.
   function automatic logic signed [63:0] sat_signed(
      input logic signed [63:0] value,
      input int unsigned        width
   );
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v)
         return max_v;
      else if (value < min_v)
         return min_v;
      else
         return value;
   endfunction

endpackage

// File: rtl/round_sat.sv
// ---------------------------------------------------------------------------
// round_sat
// Two-stage datapath of the output conditioner.
//   stage 1 : round-half-up from Q(IN_WL-IN_FL).IN_FL to an integer
//   stage 2 : saturate to OUT_WL signed bits, flag clipping, apply blanking
// A blank tag travels alongside each sample; a blanked sample leaves with
// o_valid=0 and zeroed data/flag. Latency 2, one sample per clk, no stall.
// Ports:
//   clk, arst_n  clock / async active-low reset
//   i_valid      input sample valid
//   i_blank      sample is to be suppressed at the output
//   i_data       signed fixed-point sample, IN_WL bits
//   o_valid      output sample valid
//   o_data       rounded/saturated integer, OUT_WL bits (0 when not valid)
//   o_clipped    sample was clipped (0 when not valid)
// ---------------------------------------------------------------------------
module round_sat
   import filter_pkg::*;
#(
   parameter int IN_WL  = IN_WL_DEFAULT,
   parameter int IN_FL  = IN_FL_DEFAULT,
   parameter int OUT_WL = OUT_WL_DEFAULT
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              i_valid,
   input  logic              i_blank,
   input  logic [IN_WL-1:0]  i_data,
   output logic              o_valid,
   output logic [OUT_WL-1:0] o_data,
   output logic              o_clipped
);

   // One guard bit makes the half-LSB addition overflow-free.
   localparam logic signed [IN_WL:0] C_HALF = {{IN_WL{1'b0}}, 1'b1} << (IN_FL - 1);

   logic signed [IN_WL:0] w_ext;
   logic signed [IN_WL:0] w_sum;
   logic signed [IN_WL:0] w_rnd;
   logic signed [63:0]    w_wide;
   logic signed [63:0]    w_sat;
   logic                  w_clip;

   logic                  r_s1_valid;
   logic                  r_s1_blank;
   logic signed [IN_WL:0] r_s1_rnd;

   // Adding half an LSB then shifting arithmetically rounds ties toward +inf.
   assign w_ext = {i_data[IN_WL-1], i_data};
   assign w_sum = w_ext + C_HALF;
   assign w_rnd = w_sum >>> IN_FL;

   assign w_wide = 64'(r_s1_rnd);
   assign w_sat  = sat_signed(w_wide, OUT_WL);
   assign w_clip = (w_sat != w_wide);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_blank <= 1'b0;
         r_s1_rnd   <= '0;
      end else begin
         r_s1_valid <= i_valid;
         r_s1_blank <= i_blank;
         r_s1_rnd   <= w_rnd;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_clipped <= 1'b0;
      end else if (r_s1_valid && !r_s1_blank) begin
         o_valid   <= 1'b1;
         o_data    <= w_sat[OUT_WL-1:0];
         o_clipped <= w_clip;
      end else begin
         // Idle and blanked slots drive zeros rather than holding old data.
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_clipped <= 1'b0;
      end
   end

endmodule

// File: rtl/filter_out_conditioner.sv
// ---------------------------------------------------------------------------
// filter_out_conditioner
// Output stage after the adaptive FIR/IIR filter: rounds and saturates each
// accumulator sample to an OUT_WL-bit integer, counts clipped samples and
// blanks the output while the filter settles after a diff<->integrator
// mode change (its delay line and feedback still hold stale state).
// Ports:
//   clk       clock
//   arst_n    async active-low reset (deassertion synchronised outside)
//   ctrl      filter mode (0 diff, 1 integrator); any toggle restarts settling
//   s_tvalid  input sample valid
//   s_tdata   filter sample, signed Q(IN_WL-IN_FL).IN_FL
//   sat_clr   synchronous clear of sat_cnt, wins over increment
//   m_tvalid  output sample valid (2 clk after input unless blanked)
//   m_tdata   rounded/saturated sample, 0 when m_tvalid=0
//   sat_flag  this output sample was clipped, 0 when m_tvalid=0
//   sat_cnt   clipped output samples, sticks at all-ones
//   settling  FSM is in SETTLE
// ---------------------------------------------------------------------------
module filter_out_conditioner
   import filter_pkg::*;
#(
   parameter int IN_WL         = IN_WL_DEFAULT,
   parameter int IN_FL         = IN_FL_DEFAULT,
   parameter int OUT_WL        = OUT_WL_DEFAULT,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
   parameter int SAT_CNT_WL    = SAT_CNT_WL_DEFAULT
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  ctrl,
   input  logic                  s_tvalid,
   input  logic [IN_WL-1:0]      s_tdata,
   input  logic                  sat_clr,
   output logic                  m_tvalid,
   output logic [OUT_WL-1:0]     m_tdata,
   output logic                  sat_flag,
   output logic [SAT_CNT_WL-1:0] sat_cnt,
   output logic                  settling
);

   localparam int                CNT_WL   = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_WL-1:0] C_SETTLE = CNT_WL'(SETTLE_CYCLES);
   localparam logic [CNT_WL-1:0] C_ONE    = CNT_WL'(1);

   cond_state_t           r_state;
   cond_state_t           w_state_nxt;
   logic [CNT_WL-1:0]     r_cnt;
   logic [CNT_WL-1:0]     w_cnt_nxt;
   logic                  r_ctrl_q;
   logic                  w_change;
   logic                  w_blank;
   logic [SAT_CNT_WL-1:0] r_sat_cnt;

   // Toggle detect runs every clk, independent of s_tvalid.
   assign w_change = ctrl ^ r_ctrl_q;

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state  <= SETTLE;
         r_cnt    <= C_SETTLE;
         r_ctrl_q <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ctrl_q <= ctrl;
      end
   end

   // ---- FSM: next state ----
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         RUN: begin
            if (w_change) begin
               w_state_nxt = SETTLE;
               w_cnt_nxt   = C_SETTLE;
            end
         end
         SETTLE: begin
            // A toggle restarts the window even on the would-be last sample.
            if (w_change) begin
               w_cnt_nxt = C_SETTLE;
            end else if (s_tvalid) begin
               w_cnt_nxt = r_cnt - C_ONE;
               if (r_cnt == C_ONE)
                  w_state_nxt = RUN;
            end
         end
         default: ;
      endcase
   end

   // ---- FSM: outputs ----
   // The sample entering stage 1 is tagged with the current state, so the
   // sample coincident with a toggle in RUN still passes.
   always_comb begin
      settling = (r_state == SETTLE);
      w_blank  = (r_state == SETTLE);
   end

   round_sat #(
      .IN_WL  (IN_WL),
      .IN_FL  (IN_FL),
      .OUT_WL (OUT_WL)
   ) u_round_sat (
      .clk       (clk),
      .arst_n    (arst_n),
      .i_valid   (s_tvalid),
      .i_blank   (w_blank),
      .i_data    (s_tdata),
      .o_valid   (m_tvalid),
      .o_data    (m_tdata),
      .o_clipped (sat_flag)
   );

   // Saturation event counter; sat_clr has priority, all-ones is sticky.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         r_sat_cnt <= '0;
      else if (sat_clr)
         r_sat_cnt <= '0;
      else if (m_tvalid && sat_flag && (r_sat_cnt != '1))
         r_sat_cnt <= r_sat_cnt + SAT_CNT_WL'(1);
   end

   assign sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_filter_out_conditioner.sv
// ---------------------------------------------------------------------------
// tb_filter_out_conditioner
// Directed bench with a scoreboard: each driven cycle pushes the expected
// output (computed from a real-valued rounding model and a behavioural
// settle model) which is popped two cycles later when the DUT presents it.
// ---------------------------------------------------------------------------
module tb_filter_out_conditioner;

   localparam int SETTLE_N = 16;
   localparam int SAT_MAX  = 65535;

   typedef struct {
      bit in_valid;
      bit valid;
      int data;
      bit flag;
   } exp_t;

   logic        clk    = 1'b0;
   logic        arst_n = 1'b1;
   logic        ctrl   = 1'b0;
   logic        s_tvalid = 1'b0;
   logic [23:0] s_tdata  = '0;
   logic        sat_clr  = 1'b0;
   logic        m_tvalid;
   logic [13:0] m_tdata;
   logic        sat_flag;
   logic [15:0] sat_cnt;
   logic        settling;

   exp_t q[$];
   bit   m_settle;
   int   m_cnt;
   bit   m_ctrl_q;
   int   m_sat;
   bit   cur_ctrl;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_blank  = 0;
   int   sat_before;

   filter_out_conditioner dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .ctrl     (ctrl),
      .s_tvalid (s_tvalid),
      .s_tdata  (s_tdata),
      .sat_clr  (sat_clr),
      .m_tvalid (m_tvalid),
      .m_tdata  (m_tdata),
      .sat_flag (sat_flag),
      .sat_cnt  (sat_cnt),
      .settling (settling)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference rounding/saturation in real arithmetic.
   function automatic int model_out(input logic [23:0] d, output bit clip);
      real r;
      int  v;
      r = $itor($signed(d)) / 1024.0;
      v = $rtoi($floor(r + 0.5));
      clip = 1'b0;
      if (v > 8191) begin
         v = 8191;
         clip = 1'b1;
      end else if (v < -8192) begin
         v = -8192;
         clip = 1'b1;
      end
      return v;
   endfunction

   // One clock: compare what the DUT shows now, drive the next inputs,
   // push their expected result, then advance to the next falling edge.
   task automatic step(input bit v, input logic [23:0] d, input bit c, input bit clr);
      exp_t e;
      exp_t got;
      bit   clip;
      int   val;
      bit   change;
      check("settling", settling, m_settle);
      check("sat_cnt", sat_cnt, m_sat);
      if (q.size() == 2) begin
         got = q.pop_front();
         check("m_tvalid", m_tvalid, got.valid);
         check("m_tdata", $signed(m_tdata), got.data);
         check("sat_flag", sat_flag, got.flag);
         if (got.in_valid && m_tvalid === 1'b0)
            n_blank++;
         if (clr)
            m_sat = 0;
         else if (got.valid && got.flag && m_sat != SAT_MAX)
            m_sat++;
      end else if (clr) begin
         m_sat = 0;
      end
      s_tvalid = v;
      s_tdata  = d;
      ctrl     = c;
      sat_clr  = clr;
      val        = model_out(d, clip);
      e.in_valid = v;
      e.valid    = v && !m_settle;
      e.data     = e.valid ? val : 0;
      e.flag     = e.valid ? clip : 1'b0;
      q.push_back(e);
      change   = (c != m_ctrl_q);
      m_ctrl_q = c;
      if (!m_settle) begin
         if (change) begin
            m_settle = 1'b1;
            m_cnt    = SETTLE_N;
         end
      end else if (change) begin
         m_cnt = SETTLE_N;
      end else if (v) begin
         if (m_cnt == 1)
            m_settle = 1'b0;
         m_cnt--;
      end
      @(negedge clk);
   endtask

   task automatic samp(input logic [23:0] d);
      step(1'b1, d, cur_ctrl, 1'b0);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 24'h0, cur_ctrl, 1'b0);
   endtask

   task automatic do_reset();
      arst_n   = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      ctrl     = 1'b0;
      sat_clr  = 1'b0;
      #1;
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_sat_flag", sat_flag, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_settling", settling, 1);
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      q.delete();
      m_settle = 1'b1;
      m_cnt    = SETTLE_N;
      m_ctrl_q = 1'b0;
      m_sat    = 0;
      cur_ctrl = 1'b0;
   endtask

   initial begin
      #2;
      do_reset();

      // Settling window after reset
      n_blank = 0;
      for (int i = 0; i < 20; i++) samp(24'(i * 700));
      idle(2);
      check("blank_after_reset", n_blank, SETTLE_N);

      // Rounding: 1.0, 1.5, -1.5, -2.5
      samp(24'h000400);
      samp(24'h000600);
      samp(24'hFFFA00);
      samp(24'hFFF600);
      idle(2);

      // Saturation edges
      idle(1);
      sat_before = int'(sat_cnt);
      samp(24'h7FFFFF);
      samp(24'h800000);
      samp(24'h7FF9FF);
      samp(24'h7FFE00);
      idle(3);
      check("sat_delta", int'(sat_cnt) - sat_before, 2);

      // Mode change in RUN with a continuous stream
      n_blank = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 5) cur_ctrl = ~cur_ctrl;
         samp(24'(i * 1000 - 20000));
         if (i == 5) check("settle_rise", settling, 1);
      end
      idle(2);
      check("blank_mode_change", n_blank, SETTLE_N);

      // Restart after 10 blanked samples (second toggle on an idle cycle)
      n_blank = 0;
      for (int i = 0; i < 45; i++) begin
         if (i == 3) cur_ctrl = ~cur_ctrl;
         samp(24'(i * 333));
         if (i == 13) begin
            cur_ctrl = ~cur_ctrl;
            step(1'b0, 24'h0, cur_ctrl, 1'b0);
         end
      end
      idle(2);
      check("blank_restart", n_blank, 26);

      // Toggle coinciding with the 16th blanked sample
      n_blank = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 3 || i == 19) cur_ctrl = ~cur_ctrl;
         samp(24'(-i * 517));
      end
      idle(2);
      check("blank_toggle_last", n_blank, 2 * SETTLE_N);

      // Gapped input during SETTLE: 1-of-3 valid
      n_blank = 0;
      cur_ctrl = ~cur_ctrl;
      step(1'b0, 24'h0, cur_ctrl, 1'b0);
      for (int i = 0; i < 90; i++)
         step((i % 3) == 0, 24'(i * 211), cur_ctrl, 1'b0);
      idle(2);
      check("blank_gapped", n_blank, SETTLE_N);

      // Sticky saturation counter
      repeat (65540) samp(24'h7FFFFF);
      idle(3);
      check("sat_cnt_sticky", sat_cnt, 16'hFFFF);

      // sat_clr while clipped samples are still arriving
      step(1'b1, 24'h7FFFFF, cur_ctrl, 1'b0);
      step(1'b1, 24'h7FFFFF, cur_ctrl, 1'b0);
      step(1'b1, 24'h7FFFFF, cur_ctrl, 1'b1);
      step(1'b1, 24'h7FFFFF, cur_ctrl, 1'b1);
      step(1'b1, 24'h7FFFFF, cur_ctrl, 1'b1);
      step(1'b0, 24'h0, cur_ctrl, 1'b1);
      step(1'b0, 24'h0, cur_ctrl, 1'b1);
      idle(1);
      check("sat_clr", sat_cnt, 0);

      // Reset mid-stream
      for (int i = 0; i < 5; i++) samp(24'h000400);
      check("pre_rst_valid", m_tvalid, 1);
      do_reset();
      n_blank = 0;
      for (int i = 0; i < 20; i++) samp(24'h000400);
      idle(2);
      check("blank_after_rst2", n_blank, SETTLE_N);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
